cp0_ctrl: RTL



---
 rtl/cp0_if.sv | 34 +++
 rtl/cp0_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/cp0_if.sv
// cp0_if: CP0 access, trap and redirect signals between the core and CP0.
// master = core side, slave = cp0_ctrl side.
interface cp0_if #(
  parameter int IRQ_N = 5
);
  logic             mtc0;
  logic             mfc0;
  logic [4:0]       addr;
  logic [31:0]      wdata;
  logic [31:0]      rdata;
  logic [31:0]      pc;
  logic             exc_req;
  logic [4:0]       exc_code;
  logic             eret;
  logic [IRQ_N-1:0] irq;
  logic [31:0]      status;
  logic             redirect;
  logic [31:0]      exc_addr;
  logic             timer_irq;

  modport master (
    output mtc0, mfc0, addr, wdata, pc,
    output exc_req, exc_code, eret, irq,
    input  rdata, status, redirect,
    input  exc_addr, timer_irq
  );

  modport slave (
    input  mtc0, mfc0, addr, wdata, pc,
    input  exc_req, exc_code, eret, irq,
    output rdata, status, redirect,
    output exc_addr, timer_irq
  );
endinterface

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: Status/Cause/EPC/Count/Compare, trap and ERET arbitration,
// timer interrupt and registered fetch redirect.
module cp0_ctrl #(
  parameter int          DATA_W     = 32,
  parameter int          IRQ_N      = 5,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004,
  parameter logic [31:0] STATUS_RST = 32'h0000_0000
) (
  input  logic clk,
  input  logic rst,
  cp0_if.slave bus
);

  typedef logic [DATA_W-1:0] word_t;

  localparam word_t IM_MASK =
    word_t'(((1 << (IRQ_N + 1)) - 1) << 8);
  localparam word_t ST_MASK =
    IM_MASK | word_t'(32'h3F);

  localparam logic [4:0] A_COUNT   = 5'd9;
  localparam logic [4:0] A_COMPARE = 5'd11;
  localparam logic [4:0] A_STATUS  = 5'd12;
  localparam logic [4:0] A_CAUSE   = 5'd13;
  localparam logic [4:0] A_EPC     = 5'd14;

  word_t      status_q, status_d;
  word_t      epc_q, epc_d;
  word_t      count_q, count_d;
  word_t      compare_q, compare_d;
  word_t      exc_addr_q, exc_addr_d;
  logic [4:0] code_q, code_d;
  logic [1:0] sw_q, sw_d;
  logic       tirq_q, tirq_d;
  logic       redirect_q, redirect_d;

  logic [7:0] ip;
  logic       int_pending;
  logic       take_trap;
  logic       take_eret;
  logic       wr;
  word_t      cause_rd;

  // irq lines and the software bits share IP[9:8]; the timer sits above irq
  assign ip = 8'(bus.irq)
            | {6'b0, sw_q}
            | (8'(tirq_q) << IRQ_N);

  assign int_pending = status_q[0] & |(ip & status_q[15:8]);

  assign take_trap = bus.exc_req | (~bus.eret & int_pending);
  assign take_eret = ~bus.exc_req & bus.eret;
  assign wr        = bus.mtc0 & ~take_trap & ~take_eret;

  assign cause_rd = {16'h0, ip, 1'b0, code_q, 2'b00};

  always_comb begin
    bus.rdata = '0;
    if (bus.mfc0) begin
      case (bus.addr)
        A_COUNT:   bus.rdata = count_q;
        A_COMPARE: bus.rdata = compare_q;
        A_STATUS:  bus.rdata = status_q;
        A_CAUSE:   bus.rdata = cause_rd;
        A_EPC:     bus.rdata = epc_q;
        default:   bus.rdata = '0;
      endcase
    end
  end

  always_comb begin
    status_d   = status_q;
    epc_d      = epc_q;
    count_d    = count_q + word_t'(1);
    compare_d  = compare_q;
    code_d     = code_q;
    sw_d       = sw_q;
    tirq_d     = tirq_q | (count_q == compare_q);
    redirect_d = 1'b0;
    exc_addr_d = exc_addr_q;
    unique case (1'b1)
      take_trap: begin
        epc_d         = bus.pc;
        code_d        = bus.exc_req ? bus.exc_code : 5'd0;
        status_d[5:0] = {status_q[3:0], 2'b00};
        exc_addr_d    = EXC_VECTOR;
        redirect_d    = 1'b1;
      end
      take_eret: begin
        status_d[5:0] = {status_q[5:4], status_q[5:2]};
        exc_addr_d    = epc_q;
        redirect_d    = 1'b1;
      end
      wr: begin
        case (bus.addr)
          A_COUNT:   count_d = bus.wdata;
          A_COMPARE: begin
            compare_d = bus.wdata;
            tirq_d    = 1'b0;
          end
          A_STATUS:  status_d = bus.wdata & ST_MASK;
          A_CAUSE:   sw_d = bus.wdata[9:8];
          A_EPC:     epc_d = bus.wdata;
          default:   ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q   <= STATUS_RST & ST_MASK;
      epc_q      <= '0;
      count_q    <= '0;
      compare_q  <= '1;
      code_q     <= '0;
      sw_q       <= '0;
      tirq_q     <= 1'b0;
      redirect_q <= 1'b0;
      exc_addr_q <= '0;
    end else begin
      status_q   <= status_d;
      epc_q      <= epc_d;
      count_q    <= count_d;
      compare_q  <= compare_d;
      code_q     <= code_d;
      sw_q       <= sw_d;
      tirq_q     <= tirq_d;
      redirect_q <= redirect_d;
      exc_addr_q <= exc_addr_d;
    end
  end

  assign bus.status    = status_q;
  assign bus.redirect  = redirect_q;
  assign bus.exc_addr  = exc_addr_q;
  assign bus.timer_irq = tirq_q;

endmodule
